alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001: Parameter REG_ADDR_W, default 3, register-file address width; register-file depth is 2**REG_ADDR_W words of 32 bits.
REQ-002: clk  input  1  single clock; all state updates on its rising edge.
REQ-003: reset  input  1  asynchronous, active-high reset.
REQ-004: instr_valid  input  1  upstream instruction present.
REQ-005: instr_ready  output  1  sequencer accepts an instruction this cycle.
REQ-006: instr_op  input  4  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
REQ-007: instr_rd / instr_ra / instr_rb  input  REG_ADDR_W each  destination / source-A / source-B register index.
REQ-008: alu_opcode  output  4  opcode driven to the ALU.
REQ-009: alu_exec  output  1  ALU execute enable.
REQ-010: alu_operand_A / alu_operand_B  output  32 each  ALU operands.
REQ-011: alu_result  input  32  ALU combinational result.
REQ-012: wb_valid  output  1  one-cycle writeback strobe.
REQ-013: wb_rd  output  REG_ADDR_W  register written this cycle.
REQ-014: wb_data  output  32  value written this cycle.
REQ-015: op_err  output  1  one-cycle illegal-opcode strobe.
REQ-016: dbg_addr  input  REG_ADDR_W; dbg_data  output  32  combinational register-file read port.

Function
REQ-017: FSM states: IDLE, EXEC, WB; instr_ready = 1 only in IDLE with reset deasserted.
REQ-018: IDLE: on instr_valid && instr_ready, latch instr_op into alu_opcode and instr_rd into an internal rd register, load alu_operand_A = R[instr_ra] and alu_operand_B = R[instr_rb], and go to EXEC; otherwise stay in IDLE.
REQ-019: EXEC: alu_exec = 1 for exactly one cycle; alu_result is captured into an internal result register at the end of the cycle; next state is WB.
REQ-020: WB: wb_valid = 1, wb_rd = latched rd, wb_data = captured result; R[rd] is updated at the end of the cycle; next state is IDLE.
REQ-021: alu_exec, wb_valid and op_err are 0 in every cycle not named above.
REQ-022: Throughput is one instruction per 3 cycles; latency from the accept edge to wb_valid high is 2 cycles.
REQ-023: R[0] always reads 0; a writeback to index 0 still pulses wb_valid with the computed wb_data, but R[0] is not modified.
REQ-024: Operands are sampled at the accept edge; an instruction accepted in the cycle after WB sees the updated register value (no hazard logic is required).
REQ-025: Source and destination indices may be equal (e.g. rd = ra = rb); the old value is read and the new value is written.
REQ-026: alu_opcode and alu_operand_A/B hold their last value outside EXEC.
REQ-027: dbg_data = R[dbg_addr], reflecting writes from the next cycle onward; dbg_addr 0 returns 0.

Reset
REQ-028: Reset asynchronously forces IDLE, clears every R[i] to 0, and sets alu_opcode, alu_operand_A, alu_operand_B, wb_rd, wb_data and the result register to 0; alu_exec, wb_valid, op_err and instr_ready are 0 while reset is asserted.
REQ-029: Reset asserted in EXEC or WB aborts the instruction: no writeback occurs and no wb_valid pulse follows after reset is released.

Configuration
REQ-030: Macro ALU_SEQ_ILLEGAL_OP_EN.
REQ-031: Defined: an accepted instr_op > 4 does not enter EXEC; op_err pulses for 1 cycle on the cycle after the accept, the FSM stays in IDLE (instr_ready = 0 during the op_err cycle), and neither the register file nor the wb_* outputs change.
REQ-032: Not defined: op_err is tied to 0; an opcode > 4 is executed normally and the ALU result (0) is written back to rd.

Verification
REQ-033: After reset, write R1 = 5 and R2 = 3 through seeded ADDs from R0 (required setup: the reset file is all zero, so R1 = R0 + R0 = 0; load via test backdoor or force), then ADD rd = 3, ra = 1, rb = 2 -> wb_valid 2 cycles after the accept with wb_rd = 3, wb_data = 8, and dbg_data(3) = 8.
REQ-034: R1 = 3, R2 = 5, SUB rd = 4, ra = 1, rb = 2 -> wb_data = 32'hFFFFFFFE; XOR rd = 4, ra = 4, rb = 4 -> wb_data = 0.
REQ-035: instr_valid held high with back-to-back instructions -> instr_ready pattern 1,0,0 repeating; exactly one wb_valid every 3 cycles.
REQ-036: ADD with rd = 0 and R1 = 7, R2 = 1 -> wb_valid = 1, wb_data = 8, and dbg_data(0) = 0 afterwards.
REQ-037: Reset pulsed during EXEC -> no wb_valid pulse; the whole register file reads 0; instr_ready = 1 on the first cycle after reset is released.
REQ-038: instr_op = 9: with ALU_SEQ_ILLEGAL_OP_EN -> op_err pulse, no wb_valid, R[rd] unchanged; without it -> wb_valid = 1 and wb_data = 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: IDLE/EXEC/WB sequencer driving an external ALU from a register file.
// Optional macro ALU_SEQ_ILLEGAL_OP_EN: opcodes above 4 are trapped with op_err.
module alu_sequencer #(
  parameter int REG_ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [3:0]            instr_op,
  input  logic [REG_ADDR_W-1:0] instr_rd,
  input  logic [REG_ADDR_W-1:0] instr_ra,
  input  logic [REG_ADDR_W-1:0] instr_rb,
  output logic [3:0]            alu_opcode,
  output logic                  alu_exec,
  output logic [31:0]           alu_operand_A,
  output logic [31:0]           alu_operand_B,
  input  logic [31:0]           alu_result,
  output logic                  wb_valid,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [31:0]           wb_data,
  output logic                  op_err,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [31:0]           dbg_data
);

  localparam int DEPTH = 2 ** REG_ADDR_W;
  localparam logic [3:0] OP_MAX = 4'd4;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } state_t;

  state_t state_q, state_d;

  logic [31:0]           regs [DEPTH];
  logic [REG_ADDR_W-1:0] rd_q;
  logic [31:0]           res_q;
  logic                  err_q;
  logic                  illegal;
  logic                  accept;
  logic                  start;
  logic [31:0]           rdat_a;
  logic [31:0]           rdat_b;

  // R0 is hardwired to zero on every read port
  assign rdat_a   = (instr_ra == '0) ? '0 : regs[instr_ra];
  assign rdat_b   = (instr_rb == '0) ? '0 : regs[instr_rb];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

  assign instr_ready = (state_q == IDLE) && !reset && !err_q;
  assign accept      = instr_valid && instr_ready;
  assign start       = accept && !illegal;
  assign op_err      = err_q;
  assign wb_rd       = rd_q;
  assign wb_data     = res_q;

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  assign illegal = (instr_op > OP_MAX);

  // one-cycle trap strobe after accepting an unknown opcode
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= accept && illegal;
    end
  end
`else
  assign illegal = 1'b0;
  assign err_q   = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and per-state strobes
  always_comb begin
    state_d  = state_q;
    alu_exec = 1'b0;
    wb_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        alu_exec = 1'b1;
        state_d  = WB;
      end
      WB: begin
        wb_valid = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // instruction latch, operand fetch and result capture
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_opcode    <= '0;
      alu_operand_A <= '0;
      alu_operand_B <= '0;
      rd_q          <= '0;
      res_q         <= '0;
    end else begin
      if (start) begin
        alu_opcode    <= instr_op;
        alu_operand_A <= rdat_a;
        alu_operand_B <= rdat_b;
        rd_q          <= instr_rd;
      end
      if (state_q == EXEC) begin
        res_q <= alu_result;
      end
    end
  end

  // register file; index 0 is never written
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (state_q == WB && rd_q != '0) begin
      regs[rd_q] <= res_q;
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed bench for alu_sequencer; the bench plays the ALU
// and keeps a transaction-level model checked every cycle on the falling edge.
module tb_alu_sequencer;

`ifdef ALU_SEQ_ILLEGAL_OP_EN
  localparam bit ILL_EN = 1'b1;
`else
  localparam bit ILL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  instr_op = '0;
  logic [2:0]  instr_rd = '0;
  logic [2:0]  instr_ra = '0;
  logic [2:0]  instr_rb = '0;
  logic [3:0]  alu_opcode;
  logic        alu_exec;
  logic [31:0] alu_operand_A;
  logic [31:0] alu_operand_B;
  logic [31:0] alu_result;
  logic        wb_valid;
  logic [2:0]  wb_rd;
  logic [31:0] wb_data;
  logic        op_err;
  logic [2:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  logic        seed_en = 1'b0;
  logic [31:0] seed_val = '0;

  int checks = 0;
  int failures = 0;

  alu_sequencer #(.REG_ADDR_W(3)) dut (
    .clk(clk),
    .reset(reset),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_op(instr_op),
    .instr_rd(instr_rd),
    .instr_ra(instr_ra),
    .instr_rb(instr_rb),
    .alu_opcode(alu_opcode),
    .alu_exec(alu_exec),
    .alu_operand_A(alu_operand_A),
    .alu_operand_B(alu_operand_B),
    .alu_result(alu_result),
    .wb_valid(wb_valid),
    .wb_rd(wb_rd),
    .wb_data(wb_data),
    .op_err(op_err),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(
    input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // bench-side ALU; seeding overrides the result to preload registers
  assign alu_result = seed_en ? seed_val
                    : alu_fn(alu_opcode, alu_operand_A, alu_operand_B);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // transaction-level model: one instruction in flight, age in cycles
  logic [31:0] mregs [8];
  bit          model_live = 1'b0;
  bit          in_flight = 1'b0;
  int          age = 0;
  logic [3:0]  t_op;
  logic [2:0]  t_rd;
  logic [31:0] t_a, t_b, t_res;
  bit          t_ill;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mregs[i] = '0;
      in_flight  = 1'b0;
      age        = 0;
      model_live = 1'b1;
    end else begin
      bit acc;
      acc = instr_valid && !in_flight;
      if (in_flight) begin
        if (t_ill || age == 2) begin
          if (!t_ill && t_rd != 0) mregs[t_rd] = t_res;
          in_flight = 1'b0;
        end else begin
          age++;
        end
      end
      if (acc) begin
        in_flight = 1'b1;
        age   = 1;
        t_op  = instr_op;
        t_rd  = instr_rd;
        t_a   = mregs[instr_ra];
        t_b   = mregs[instr_rb];
        t_ill = ILL_EN && (instr_op > 4'd4);
        t_res = seed_en ? seed_val : alu_fn(t_op, t_a, t_b);
      end
    end
  end

  // compare DUT against the model on every falling edge
  always @(negedge clk) begin
    if (model_live) begin
      bit m_ready, m_exec, m_wb, m_err;
      m_ready = !reset && !in_flight;
      m_exec  = in_flight && age == 1 && !t_ill;
      m_err   = in_flight && t_ill;
      m_wb    = in_flight && age == 2;
      chk("instr_ready", instr_ready, m_ready);
      chk("alu_exec", alu_exec, m_exec);
      chk("wb_valid", wb_valid, m_wb);
      chk("op_err", op_err, m_err);
      chk("dbg_data", dbg_data, mregs[dbg_addr]);
      if (m_exec) begin
        chk("alu_opcode", alu_opcode, t_op);
        chk("alu_operand_A", alu_operand_A, t_a);
        chk("alu_operand_B", alu_operand_B, t_b);
      end
      if (m_wb) begin
        chk("wb_rd", wb_rd, t_rd);
        chk("wb_data", wb_data, t_res);
      end
    end
  end

  // present an instruction and return just after its accept edge
  task automatic issue(input logic [3:0] op, input logic [2:0] rd,
                       input logic [2:0] ra, input logic [2:0] rb);
    int n = 0;
    instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb;
    instr_valid = 1'b1;
    @(negedge clk);
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (n >= 10) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // run one instruction to completion and pin its writeback to a literal
  task automatic run(input logic [3:0] op, input logic [2:0] rd,
                     input logic [2:0] ra, input logic [2:0] rb,
                     input logic [31:0] lit);
    issue(op, rd, ra, rb);
    @(negedge clk);
    chk("lit_exec", alu_exec, 1);
    @(negedge clk);
    chk("lit_wb_valid", wb_valid, 1);
    chk("lit_wb_rd", wb_rd, rd);
    chk("lit_wb_data", wb_data, lit);
    @(posedge clk); #1;
    dbg_addr = rd;
    @(negedge clk);
    chk("lit_dbg", dbg_data, (rd == 0) ? 32'd0 : lit);
    @(posedge clk); #1;
  endtask

  task automatic seed(input logic [2:0] rd, input logic [31:0] v);
    seed_en = 1'b1;
    seed_val = v;
    run(4'd0, rd, 3'd0, 3'd0, v);
    seed_en = 1'b0;
  endtask

  logic [3:0]  b_op [3];
  logic [2:0]  b_rd [3];
  logic [31:0] b_lit [3];

  initial begin
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", instr_ready, 0);
    chk("rst_exec", alu_exec, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_op_err", op_err, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_opcode", alu_opcode, 0);
    chk("rst_operand_A", alu_operand_A, 0);
    chk("rst_operand_B", alu_operand_B, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    seed(3'd1, 32'd5);
    seed(3'd2, 32'd3);
    run(4'd0, 3'd3, 3'd1, 3'd2, 32'd8);

    seed(3'd1, 32'd3);
    seed(3'd2, 32'd5);
    run(4'd1, 3'd4, 3'd1, 3'd2, 32'hFFFF_FFFE);
    run(4'd4, 3'd4, 3'd4, 3'd4, 32'd0);

    b_op[0] = 4'd0; b_rd[0] = 3'd5; b_lit[0] = 32'd8;
    b_op[1] = 4'd3; b_rd[1] = 3'd6; b_lit[1] = 32'd7;
    b_op[2] = 4'd2; b_rd[2] = 3'd7; b_lit[2] = 32'd1;
    instr_op = b_op[0]; instr_rd = b_rd[0];
    instr_ra = 3'd1; instr_rb = 3'd2;
    instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("b2b_ready", instr_ready, (i % 3 == 0) ? 1 : 0);
      chk("b2b_wb_valid", wb_valid, (i % 3 == 2) ? 1 : 0);
      if (i % 3 == 2) chk("b2b_wb_data", wb_data, b_lit[i / 3]);
      @(posedge clk); #1;
      if (i % 3 == 0) begin
        if (i / 3 + 1 < 3) begin
          instr_op = b_op[i / 3 + 1];
          instr_rd = b_rd[i / 3 + 1];
        end else begin
          instr_valid = 1'b0;
        end
      end
    end

    seed(3'd1, 32'd7);
    seed(3'd2, 32'd1);
    run(4'd0, 3'd0, 3'd1, 3'd2, 32'd8);

    issue(4'd9, 3'd5, 3'd1, 3'd2);
`ifdef ALU_SEQ_ILLEGAL_OP_EN
    @(negedge clk);
    chk("ill_op_err", op_err, 1);
    chk("ill_ready", instr_ready, 0);
    chk("ill_exec", alu_exec, 0);
    @(negedge clk);
    chk("ill_wb_valid", wb_valid, 0);
    chk("ill_ready_back", instr_ready, 1);
    @(posedge clk); #1;
    dbg_addr = 3'd5;
    @(negedge clk);
    chk("ill_r5_kept", dbg_data, 32'd8);
`else
    @(negedge clk);
    chk("ill_op_err", op_err, 0);
    @(negedge clk);
    chk("ill_wb_valid", wb_valid, 1);
    chk("ill_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    dbg_addr = 3'd5;
    @(negedge clk);
    chk("ill_r5_written", dbg_data, 32'd0);
`endif
    @(posedge clk); #1;

    issue(4'd0, 3'd3, 3'd1, 3'd2);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_ready", instr_ready, 0);
    chk("abort_exec", alu_exec, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_after", instr_ready, 1);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      dbg_addr = 3'(i);
      @(negedge clk);
      chk("abort_no_wb", wb_valid, 0);
      chk("abort_reg_clear", dbg_data, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
